// File: rtl/senone_score_buffer.sv
// Per-frame senone score store: captures GDP results into a score RAM, tracks the best
// score/index, and serves post-frame beam-pruning reads with an "active" flag.
module senone_score_buffer #(
    parameter int unsigned N_SENONES = 256,
    parameter int unsigned SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [7:0]         senone_index,
    input  logic [SCORE_W-1:0] senone_score,
    input  logic               score_ready,
    input  logic               gdp_idle,
    input  logic [SCORE_W-1:0] beam,
    input  logic               rd_en,
    input  logic [7:0]         rd_addr,
    output logic               rd_valid,
    output logic [SCORE_W-1:0] rd_data,
    output logic               rd_active,
    output logic [SCORE_W-1:0] best_score,
    output logic [7:0]         best_index,
    output logic               frame_done,
    output logic               busy,
    output logic               incomplete,
    output logic               overflow_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    localparam logic [8:0]         N_LIM     = 9'(N_SENONES);
    localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W+1:0] THR_MIN   = {3'b111, {(SCORE_W-1){1'b0}}};

    logic [SCORE_W-1:0] mem [N_SENONES];

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [7:0]         best_index_q, best_index_d;
    logic [8:0]         count_q, count_d;
    logic               incomplete_q, incomplete_d;
    logic               overflow_q, overflow_d;
    logic               frame_done_q, frame_done_d;
    logic               rd_valid_q;
    logic [SCORE_W-1:0] rd_data_q;
    logic               rd_active_q;

    logic               accept;
    logic               idx_ok;
    logic               wr_en;
    logic               rd_ok;
    logic               addr_ok;
    logic [SCORE_W-1:0] rd_word;
    logic [SCORE_W+1:0] thr_wide;
    logic [SCORE_W-1:0] thr;

    always_comb begin
        accept = (state_q == S_COLLECT) && score_ready && !frame_start;
        idx_ok = {1'b0, senone_index} < N_LIM;
        wr_en  = accept && idx_ok;
    end

    always_comb begin
        state_d      = state_q;
        best_score_d = best_score_q;
        best_index_d = best_index_q;
        count_d      = count_q;
        incomplete_d = incomplete_q;
        overflow_d   = overflow_q;
        if (frame_start) begin
            state_d      = S_COLLECT;
            best_score_d = SCORE_MIN;
            best_index_d = '0;
            count_d      = '0;
            incomplete_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (idx_ok) begin
                            if (count_q != N_LIM) count_d = count_q + 9'd1;
                            // Strict compare: ties keep the earlier-accepted index.
                            if ($signed(senone_score) > $signed(best_score_q)) begin
                                best_score_d = senone_score;
                                best_index_d = senone_index;
                            end
                            if (count_q + 9'd1 == N_LIM) state_d = S_DONE;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (gdp_idle && count_q != '0) begin
                        state_d      = S_DONE;
                        incomplete_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        frame_done_d = (state_q != S_DONE) && (state_d == S_DONE);
    end

    // Threshold carries two guard bits so best - beam can never wrap before saturation.
    always_comb begin
        rd_ok    = rd_en && (state_q != S_COLLECT);
        addr_ok  = {1'b0, rd_addr} < N_LIM;
        rd_word  = addr_ok ? mem[rd_addr] : '0;
        thr_wide = $signed({{2{best_score_q[SCORE_W-1]}}, best_score_q}) - $signed({2'b00, beam});
        thr      = ($signed(thr_wide) < $signed(THR_MIN)) ? SCORE_MIN : thr_wide[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[senone_index] <= senone_score;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            best_score_q <= SCORE_MIN;
            best_index_q <= '0;
            count_q      <= '0;
            incomplete_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_active_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_score_q <= best_score_d;
            best_index_q <= best_index_d;
            count_q      <= count_d;
            incomplete_q <= incomplete_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_ok;
            if (rd_ok) begin
                rd_data_q   <= rd_word;
                rd_active_q <= addr_ok && ($signed(rd_word) >= $signed(thr));
            end else begin
                rd_active_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_valid     = rd_valid_q;
        rd_data      = rd_data_q;
        rd_active    = rd_active_q;
        best_score   = best_score_q;
        best_index   = best_index_q;
        frame_done   = frame_done_q;
        busy         = (state_q == S_COLLECT);
        incomplete   = incomplete_q;
        overflow_err = overflow_q;
    end

endmodule
